// File: rtl/demux4_pkg.sv
// rtl/demux4_pkg.sv - shared types and constants for the 1-to-4 stream demultiplexer
package demux4_pkg;

    // Destination channel carried alongside each input word
    typedef logic [1:0] chan_sel_t;

    localparam int NUM_CH = 4;

    // Per-channel holding register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - single-entry holding register with valid state for one output channel
module demux_slot
    import demux4_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         ready,
    output logic [N-1:0] data,
    output logic         valid
);

    chan_state_e state;

    // A load always wins over a drain so a word taken and replaced in the same
    // cycle leaves the slot FULL with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state <= FULL;
                        data  <= load_data;
                    end
                end
                FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Valid is the state flop itself, so it cannot glitch
    assign valid = (state == FULL);

endmodule

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - registered 1-to-4 stream demux; DEMUX4_STREAM_COUNT_EN adds per-channel counters
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_data,
    input  chan_sel_t             in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N-1:0]          out_data_0,
    output logic [N-1:0]          out_data_1,
    output logic [N-1:0]          out_data_2,
    output logic [N-1:0]          out_data_3,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [3:0][CNT_W-1:0] cnt
);

    logic                       acc;
    logic [NUM_CH-1:0]          load;
    logic [NUM_CH-1:0][N-1:0]   slot_data;

    // Only the addressed channel can stall the producer; a full slot that is
    // draining this cycle still has room, which keeps full-rate streaming.
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    end

    assign acc = in_valid & in_ready;

    // Decode the accepted word onto exactly one channel's load strobe
    always_comb begin
        load = '0;
        if (acc) begin
            load[in_sel] = 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_slot
            demux_slot #(
                .N (N)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load[k]),
                .load_data (in_data),
                .ready     (out_ready[k]),
                .data      (slot_data[k]),
                .valid     (out_valid[k])
            );
        end
    endgenerate

    assign out_data_0 = slot_data[0];
    assign out_data_1 = slot_data[1];
    assign out_data_2 = slot_data[2];
    assign out_data_3 = slot_data[3];

`ifdef DEMUX4_STREAM_COUNT_EN
    logic [3:0][CNT_W-1:0] cnt_r;

    // Count accepted words per destination; plain wrap-around, no saturation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i]) begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                end
            end
        end
    end

    assign cnt = cnt_r;
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - scoreboard bench for demux4_stream with randomized traffic
module tb_demux4_stream;

    localparam int N = 8;
`ifdef DEMUX4_STREAM_COUNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          in_data = '0;
    logic [1:0]            in_sel = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N-1:0]          out_data_0, out_data_1, out_data_2, out_data_3;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready = 4'b0000;
    logic [3:0][CNT_W-1:0] cnt;

    demux4_stream #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    typedef logic [N-1:0] word_q_t[$];
    word_q_t sb[4];
    int      exp_cnt[4];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      v2_cycles = 0;
    bit      mon_en = 1'b0;
    bit      rand_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] od(input int k);
        case (k)
            0: return out_data_0;
            1: return out_data_1;
            2: return out_data_2;
            default: return out_data_3;
        endcase
    endfunction

    function automatic int cnt_model(input int k);
`ifdef DEMUX4_STREAM_COUNT_EN
        return exp_cnt[k] % (1 << CNT_W);
`else
        return 0;
`endif
    endfunction

    // An accepted word is owed to its channel's consumer, in order
    task automatic note_accept(input logic [1:0] s, input logic [N-1:0] d);
        sb[s].push_back(d);
        exp_cnt[s] = exp_cnt[s] + 1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            exp_cnt[k] = 0;
        end
    endtask

    // Monitor: a channel is occupied exactly while one owed word is pending
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                chk("in_ready", in_ready, (sb[in_sel].size() == 0) || out_ready[in_sel]);
                if (out_valid[2]) v2_cycles++;
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("out_valid[%0d]", k), out_valid[k], sb[k].size() != 0);
                    if (out_valid[k] && sb[k].size() > 0) begin
                        chk($sformatf("out_data_%0d", k), od(k), sb[k][0]);
                        if (out_ready[k]) void'(sb[k].pop_front());
                    end
                    chk($sformatf("cnt[%0d]", k), cnt[k], cnt_model(k));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 4'($urandom);
        end
    end

    task automatic send(input logic [1:0] s, input logic [N-1:0] d, output int stalls);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            note_accept(s, d);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_cnt", cnt, '0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    int st;
    int tot;

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_out_data", {out_data_3, out_data_2, out_data_1, out_data_0}, 32'h0);
        chk("reset_cnt", cnt, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Routing: each word lands on its selected channel one cycle later
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 8'hA0 + 8'(k), st);
            chk("route_valid", out_valid[k], 1'b1);
            chk("route_data", od(k), 8'hA0 + 8'(k));
        end
        idle(2);

        // Back-pressure on channel 1 stalls a second word until it drains
        out_ready = 4'b1101;
        send(2'd1, 8'h11, st);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'h22;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("bp_release", in_ready, 1'b1);
        chk("bp_old_data", out_data_1, 8'h11);
        @(posedge clk);
        note_accept(2'd1, 8'h22);
        #1;
        chk("bp_new_data", out_data_1, 8'h22);
        chk("bp_no_bubble", out_valid[1], 1'b1);
        idle(2);

        // Independence: stalled channel 3 does not block channel 0
        out_ready = 4'b0111;
        send(2'd3, 8'h33, st);
        send(2'd0, 8'h55, st);
        chk("indep_stalls", st, 0);
        chk("indep_data0", out_data_0, 8'h55);
        chk("indep_ch3_valid", out_valid[3], 1'b1);
        chk("indep_ch3_data", out_data_3, 8'h33);
        idle(1);
        out_ready = 4'b1111;
        idle(2);

        // Full rate to channel 2
        v2_cycles = 0;
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send(2'd2, 8'($urandom), st);
            tot += st;
        end
        idle(3);
        chk("fullrate_stalls", tot, 0);
        chk("fullrate_valid_cycles", v2_cycles, 16);

        // Reset mid-operation with channel 2 holding a word
        out_ready = 4'b1011;
        send(2'd2, 8'h77, st);
        pulse_reset();

        // Counters with wrap on channel 0
        out_ready = 4'b1111;
        for (int i = 0; i < 17; i++) send(2'd0, 8'(i), st);
        for (int i = 0; i < 3; i++) send(2'd3, 8'(8'hC0 + i), st);
        idle(2);
`ifdef DEMUX4_STREAM_COUNT_EN
        chk("cnt0_wrap", cnt[0], CNT_W'(1));
        chk("cnt3", cnt[3], CNT_W'(3));
`else
        chk("cnt0_off", cnt[0], CNT_W'(0));
        chk("cnt3_off", cnt[3], CNT_W'(0));
`endif
        chk("cnt1", cnt[1], CNT_W'(0));
        chk("cnt2", cnt[2], CNT_W'(0));

        // Randomized traffic with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(2'($urandom), 8'($urandom), st);
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        #1;
        out_ready = 4'b1111;
        idle(3);
        chk("drain_empty", out_valid, 4'b0000);
        chk("drain_sb", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
